// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, line idles high.
// Each bit lasts CLKS_PER_BIT clocks; o_TX_Active spans start..stop and
// o_TX_Done pulses for one cycle when the stop bit ends.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] CLEANUP = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY  = 3'd5;
`endif

    logic [2:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    data;
    logic          serial;
    logic          active;
    logic          done;
    logic          bit_end;

    // Last clock of the current bit period
    always_comb begin
        bit_end = (clk_cnt == LAST_CLK);
    end

    // Frame sequencer; the line value is registered one step ahead of each bit
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            data    <= '0;
            serial  <= 1'b1;
            active  <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    serial  <= 1'b1;
                    active  <= 1'b0;
                    done    <= 1'b0;
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (i_TX_DV) begin
                        data   <= i_TX_Byte;
                        serial <= 1'b0;
                        active <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        serial  <= data[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            serial  <= ^data;
                            state   <= PARITY;
`else
                            serial  <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            serial  <= data[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        serial  <= 1'b1;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        active  <= 1'b0;
                        done    <= 1'b1;
                        state   <= CLEANUP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                CLEANUP: begin
                    serial <= 1'b1;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    serial <= 1'b1;
                    active <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Status and line outputs come straight from registers
    always_comb begin
        o_TX_Active = active;
        o_TX_Serial = serial;
        o_TX_Done   = done;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at CLKS_PER_BIT=434 and =4.
// Honours UART_TX_PARITY_EN to select the expected frame shapes.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] EXP_0F = 11'b10000011110;
    localparam logic [10:0] EXP_A5 = 11'b10101001010;
    localparam logic [10:0] EXP_3C = 11'b10001111000;
    localparam logic [10:0] EXP_00 = 11'b10000000000;
    localparam logic [10:0] EXP_07 = 11'b11000001110;
    localparam logic [10:0] EXP_03 = 11'b10000000110;
`else
    localparam int NB = 10;
    localparam logic [10:0] EXP_0F = 11'b01000011110;
    localparam logic [10:0] EXP_A5 = 11'b01101001010;
    localparam logic [10:0] EXP_3C = 11'b01001111000;
    localparam logic [10:0] EXP_00 = 11'b01000000000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dv_a = 1'b0, dv_b = 1'b0;
    logic [7:0] byte_a = '0, byte_b = '0;
    logic       act_a, ser_a, done_a;
    logic       act_b, ser_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(434)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv_a), .i_TX_Byte(byte_a),
        .o_TX_Active(act_a), .o_TX_Serial(ser_a), .o_TX_Done(done_a)
    );

    uart_tx #(.CLKS_PER_BIT(4)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_TX_DV(dv_b), .i_TX_Byte(byte_b),
        .o_TX_Active(act_b), .o_TX_Serial(ser_b), .o_TX_Done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one byte on DUT sel (0: 434 clk/bit, 1: 4 clk/bit) and record the
    // frame. k=0 is the sample just after the accepting edge.
    task automatic capture(input int sel, input logic [7:0] b, input int last,
                           input int inject_k, output logic [10:0] bits,
                           output int act_cnt, output int done_cnt,
                           output int done_k, output int low_cnt,
                           output int first_high);
        int cpb;
        logic s, a, d;
        cpb = (sel != 0) ? 4 : 434;
        bits = '0; act_cnt = 0; done_cnt = 0; done_k = -1; low_cnt = 0;
        first_high = -1;
        if (sel != 0) begin byte_b = b; dv_b = 1'b1; end
        else          begin byte_a = b; dv_a = 1'b1; end
        tick();
        dv_a = 1'b0; dv_b = 1'b0;
        for (int k = 0; k <= last; k++) begin
            s = (sel != 0) ? ser_b  : ser_a;
            a = (sel != 0) ? act_b  : act_a;
            d = (sel != 0) ? done_b : done_a;
            if (a) act_cnt++;
            if (d) begin done_cnt++; if (done_k < 0) done_k = k; end
            if (!s) low_cnt++;
            if (s && first_high < 0) first_high = k;
            for (int i = 0; i < NB; i++)
                if (k == i * cpb + cpb / 2) bits[i] = s;
            if (k == inject_k) begin
                if (sel != 0) begin dv_b = 1'b1; byte_b = 8'hA5; end
                else          begin dv_a = 1'b1; byte_a = 8'hA5; end
            end
            if (k == inject_k + 1) begin dv_a = 1'b0; dv_b = 1'b0; end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({ser_a, act_a, done_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_a: ser/act/done=%b required 100", {ser_a, act_a, done_a});
        end
        n_checks++;
        if ({ser_b, act_b, done_b} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_b: ser/act/done=%b required 100", {ser_b, act_b, done_b});
        end
        rst = 1'b0;
        repeat (5) tick();
        n_checks++;
        if ({ser_a, act_a, done_a, ser_b, act_b, done_b} !== 6'b100100) begin
            n_fail++;
            $display("FAIL idle_hold: got %b required 100100",
                     {ser_a, act_a, done_a, ser_b, act_b, done_b});
        end
    endtask

    task automatic test_frame_0f();
        logic [10:0] bits;
        int ac, dc, dk, lc, fh;
        capture(0, 8'h0F, NB * 434 + 3, -10, bits, ac, dc, dk, lc, fh);
        n_checks++;
        if (bits !== EXP_0F) begin
            n_fail++; $display("FAIL frame_0f_bits: got %b required %b", bits, EXP_0F);
        end
        n_checks++;
        if (ac !== NB * 434) begin
            n_fail++; $display("FAIL frame_0f_active: got %0d required %0d", ac, NB * 434);
        end
        n_checks++;
        if (dc !== 1 || dk !== NB * 434) begin
            n_fail++;
            $display("FAIL frame_0f_done: count %0d at %0d required 1 at %0d", dc, dk, NB * 434);
        end
    endtask

    task automatic test_ignore_dv();
        logic [10:0] bits;
        int ac, dc, dk, lc, fh;
        capture(0, 8'h0F, NB * 434 + 3, 2000, bits, ac, dc, dk, lc, fh);
        n_checks++;
        if (bits !== EXP_0F) begin
            n_fail++; $display("FAIL ignore_dv_bits: got %b required %b", bits, EXP_0F);
        end
        n_checks++;
        if (ac !== NB * 434 || dc !== 1) begin
            n_fail++;
            $display("FAIL ignore_dv_timing: active %0d done %0d required %0d and 1", ac, dc, NB * 434);
        end
        capture(0, 8'hA5, NB * 434 + 3, -10, bits, ac, dc, dk, lc, fh);
        n_checks++;
        if (bits !== EXP_A5 || dc !== 1) begin
            n_fail++;
            $display("FAIL frame_a5: bits %b done %0d required %b and 1", bits, dc, EXP_A5);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits;
        int ac, dc, dk, lc, fh;
        int seen_done;
        seen_done = 0;
        byte_a = 8'hF0; dv_a = 1'b1;
        tick();
        dv_a = 1'b0;
        for (int k = 0; k < 4 * 434 + 100; k++) begin
            if (done_a) seen_done++;
            tick();
        end
        n_checks++;
        if (ser_a !== 1'b0 || act_a !== 1'b1) begin
            n_fail++; $display("FAIL bit3_before_reset: ser %b act %b required 0 1", ser_a, act_a);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({ser_a, act_a, done_a} !== 3'b100 || seen_done !== 0) begin
            n_fail++;
            $display("FAIL mid_reset: ser/act/done=%b dones %0d required 100 and 0",
                     {ser_a, act_a, done_a}, seen_done);
        end
        rst = 1'b0;
        capture(0, 8'h3C, NB * 434 + 3, -10, bits, ac, dc, dk, lc, fh);
        n_checks++;
        if (bits !== EXP_3C || dc !== 1 || ac !== NB * 434) begin
            n_fail++;
            $display("FAIL after_reset_frame: bits %b done %0d active %0d required %b 1 %0d",
                     bits, dc, ac, EXP_3C, NB * 434);
        end
    endtask

    task automatic test_short_bits();
        logic [10:0] bits;
        int ac, dc, dk, lc, fh;
        capture(1, 8'h00, NB * 4 + 3, -10, bits, ac, dc, dk, lc, fh);
        n_checks++;
        if (lc !== (NB - 1) * 4 || fh !== (NB - 1) * 4) begin
            n_fail++;
            $display("FAIL short_low: low %0d first high %0d required %0d", lc, fh, (NB - 1) * 4);
        end
        n_checks++;
        if (dk !== NB * 4 || dc !== 1 || ac !== NB * 4) begin
            n_fail++;
            $display("FAIL short_done: done at %0d count %0d active %0d required %0d 1 %0d",
                     dk, dc, ac, NB * 4, NB * 4);
        end
        n_checks++;
        if (bits !== EXP_00) begin
            n_fail++; $display("FAIL short_bits: got %b required %b", bits, EXP_00);
        end
        capture(1, 8'hA5, NB * 4 + 3, -10, bits, ac, dc, dk, lc, fh);
        n_checks++;
        if (bits !== EXP_A5) begin
            n_fail++; $display("FAIL short_a5: got %b required %b", bits, EXP_A5);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits;
        int ac, dc, dk, lc, fh;
        // Ends just after the edge that raises Done (state CLEANUP)
        capture(1, 8'h3C, NB * 4 - 1, -10, bits, ac, dc, dk, lc, fh);
        n_checks++;
        if (done_b !== 1'b1 || act_b !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done: done %b act %b required 1 0", done_b, act_b);
        end
        dv_b = 1'b1; byte_b = 8'h0F;
        tick();
        n_checks++;
        if (act_b !== 1'b0 || ser_b !== 1'b1 || done_b !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_cleanup_dv: act %b ser %b done %b required 0 1 0", act_b, ser_b, done_b);
        end
        tick();
        dv_b = 1'b0;
        n_checks++;
        if (act_b !== 1'b1 || ser_b !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: act %b ser %b required 1 0", act_b, ser_b);
        end
        repeat (NB * 4 + 4) tick();
        n_checks++;
        if (act_b !== 1'b0 || ser_b !== 1'b1) begin
            n_fail++; $display("FAIL b2b_end: act %b ser %b required 0 1", act_b, ser_b);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [10:0] bits;
        int ac, dc, dk, lc, fh;
        capture(1, 8'h07, NB * 4 + 3, -10, bits, ac, dc, dk, lc, fh);
        n_checks++;
        if (bits !== EXP_07 || ac !== 44) begin
            n_fail++;
            $display("FAIL parity_07: bits %b active %0d required %b 44", bits, ac, EXP_07);
        end
        capture(1, 8'h03, NB * 4 + 3, -10, bits, ac, dc, dk, lc, fh);
        n_checks++;
        if (bits !== EXP_03) begin
            n_fail++; $display("FAIL parity_03: got %b required %b", bits, EXP_03);
        end
    endtask
`endif

    initial begin
        tick();
        test_reset();
        test_frame_0f();
        test_ignore_dv();
        test_reset_mid_frame();
        test_short_bits();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
